// File: rtl/noc_rr_port_arb.sv
// Round-robin output-port arbiter for a NoC router: grants one requesting input port
// and holds it for a whole packet, released by flit count or by a tail flag.
module noc_rr_port_arb #(
    parameter int NUM_PORTS = 5,
    parameter int PKT_FLITS = 5,
    parameter int TAIL_MODE = 0,
    localparam int IDX_W = $clog2(NUM_PORTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] mask_i,
    input  logic                 valid_i,
    input  logic                 tail_i,
    output logic [IDX_W-1:0]     grant_idx_o,
    output logic [NUM_PORTS-1:0] grant_oh_o,
    output logic                 grant_vld_o,
    output logic [7:0]           flit_cnt_o
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state;
    logic [IDX_W-1:0]     rr_ptr;
    logic [NUM_PORTS-1:0] eligible;
    logic                 pick_vld;
    logic [IDX_W-1:0]     pick_idx;
    logic                 release_pkt;

    // Scan from the farthest offset down so the port closest to rr_ptr wins.
    always_comb begin
        eligible = req_i & ~mask_i;
        pick_vld = 1'b0;
        pick_idx = '1;
        for (int off = NUM_PORTS - 1; off >= 0; off--) begin
            if (eligible[(int'(rr_ptr) + off) % NUM_PORTS]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'((int'(rr_ptr) + off) % NUM_PORTS);
            end
        end
    end

    generate
        if (TAIL_MODE != 0) begin : g_tail
            assign release_pkt = (state == LOCKED) && valid_i && tail_i;
        end else begin : g_count
            assign release_pkt = (state == LOCKED) && valid_i &&
                                 (flit_cnt_o == 8'(PKT_FLITS - 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            flit_cnt_o  <= '0;
            grant_vld_o <= 1'b0;
            grant_oh_o  <= '0;
            grant_idx_o <= '1;
        end else if (state == IDLE) begin
            if (pick_vld) begin
                state       <= LOCKED;
                grant_vld_o <= 1'b1;
                grant_idx_o <= pick_idx;
                grant_oh_o  <= NUM_PORTS'(1) << pick_idx;
                flit_cnt_o  <= '0;
            end
        end else begin
            if (release_pkt) begin
                state       <= IDLE;
                grant_vld_o <= 1'b0;
                grant_oh_o  <= '0;
                grant_idx_o <= '1;
                flit_cnt_o  <= '0;
                rr_ptr      <= (grant_idx_o == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx_o + 1'b1;
            end else if (valid_i && flit_cnt_o != 8'hFF) begin
                flit_cnt_o <= flit_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_rr_port_arb.sv
// Directed bench for noc_rr_port_arb: count-release, tail-release and single-flit instances.
module tb_noc_rr_port_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req, mask;
    logic       valid, tail;

    logic [2:0] idx0, idx1, idx2;
    logic [4:0] oh0, oh1, oh2;
    logic       vld0, vld1, vld2;
    logic [7:0] cnt0, cnt1, cnt2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    noc_rr_port_arb #(.NUM_PORTS(5), .PKT_FLITS(5), .TAIL_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .req_i(req), .mask_i(mask), .valid_i(valid), .tail_i(tail),
        .grant_idx_o(idx0), .grant_oh_o(oh0), .grant_vld_o(vld0), .flit_cnt_o(cnt0));

    noc_rr_port_arb #(.NUM_PORTS(5), .PKT_FLITS(5), .TAIL_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .req_i(req), .mask_i(mask), .valid_i(valid), .tail_i(tail),
        .grant_idx_o(idx1), .grant_oh_o(oh1), .grant_vld_o(vld1), .flit_cnt_o(cnt1));

    noc_rr_port_arb #(.NUM_PORTS(5), .PKT_FLITS(1), .TAIL_MODE(0)) dut2 (
        .clk(clk), .rst(rst), .req_i(req), .mask_i(mask), .valid_i(valid), .tail_i(tail),
        .grant_idx_o(idx2), .grant_oh_o(oh2), .grant_vld_o(vld2), .flit_cnt_o(cnt2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; mask = '0; valid = 1'b0; tail = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (vld0 !== 1'b0 || idx0 !== 3'd7 || oh0 !== 5'b0 || cnt0 !== 8'd0 ||
            vld1 !== 1'b0 || idx1 !== 3'd7 || vld2 !== 1'b0 || idx2 !== 3'd7) begin
            miscompares++;
            $display("FAIL reset: vld=%b idx=%0d oh=%b cnt=%0d (t1 %b/%0d, p1 %b/%0d) want 0/7/00000/0",
                     vld0, idx0, oh0, cnt0, vld1, idx1, vld2, idx2);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 5'b00100;
        step();
        vectors++;
        if (vld0 !== 1'b1 || idx0 !== 3'd2 || oh0 !== 5'b00100 || cnt0 !== 8'd0) begin
            miscompares++;
            $display("FAIL single_grant: vld=%b idx=%0d oh=%b cnt=%0d want 1/2/00100/0", vld0, idx0, oh0, cnt0);
        end
        req = '0; valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++;
            if (vld0 !== 1'b1 || idx0 !== 3'd2 || cnt0 !== 8'(i)) begin
                miscompares++;
                $display("FAIL single_count%0d: vld=%b idx=%0d cnt=%0d want 1/2/%0d", i, vld0, idx0, cnt0, i);
            end
        end
        step();
        vectors++;
        if (vld0 !== 1'b0 || idx0 !== 3'd7 || oh0 !== 5'b0 || cnt0 !== 8'd0) begin
            miscompares++;
            $display("FAIL single_release: vld=%b idx=%0d oh=%b cnt=%0d want 0/7/00000/0", vld0, idx0, oh0, cnt0);
        end
        valid = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 5'b11111; valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if (vld0 !== 1'b1 || idx0 !== 3'(k % 5) || oh0 !== 5'(1 << (k % 5)) || cnt0 !== 8'd0) begin
                miscompares++;
                $display("FAIL rr_grant%0d: vld=%b idx=%0d oh=%b cnt=%0d want 1/%0d", k, vld0, idx0, oh0, cnt0, k % 5);
            end
            repeat (4) step();
            vectors++;
            if (vld0 !== 1'b1 || cnt0 !== 8'd4) begin
                miscompares++;
                $display("FAIL rr_cnt%0d: vld=%b cnt=%0d want 1/4", k, vld0, cnt0);
            end
            step();
            vectors++;
            if (vld0 !== 1'b0 || idx0 !== 3'd7) begin
                miscompares++;
                $display("FAIL rr_bubble%0d: vld=%b idx=%0d want 0/7", k, vld0, idx0);
            end
        end
        req = '0; valid = 1'b0;
    endtask

    task automatic test_mask_hold();
        do_reset();
        req = 5'b00011; mask = 5'b00001;
        step();
        vectors++;
        if (vld0 !== 1'b1 || idx0 !== 3'd1 || oh0 !== 5'b00010) begin
            miscompares++;
            $display("FAIL mask_grant: vld=%b idx=%0d oh=%b want 1/1/00010", vld0, idx0, oh0);
        end
        req = '0; mask = 5'b11111; valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            vectors++;
            if (vld0 !== 1'b1 || idx0 !== 3'd1 || cnt0 !== 8'(i)) begin
                miscompares++;
                $display("FAIL mask_hold%0d: vld=%b idx=%0d cnt=%0d want 1/1/%0d", i, vld0, idx0, cnt0, i);
            end
        end
        step();
        vectors++;
        if (vld0 !== 1'b0 || idx0 !== 3'd7) begin
            miscompares++;
            $display("FAIL mask_release: vld=%b idx=%0d want 0/7", vld0, idx0);
        end
        valid = 1'b0; mask = '0;
    endtask

    task automatic test_regrant();
        do_reset();
        req = 5'b00100;
        step();
        valid = 1'b1;
        repeat (5) step();
        vectors++;
        if (vld0 !== 1'b0) begin
            miscompares++;
            $display("FAIL regrant_bubble: vld=%b want 0", vld0);
        end
        step();
        vectors++;
        if (vld0 !== 1'b1 || idx0 !== 3'd2 || cnt0 !== 8'd0) begin
            miscompares++;
            $display("FAIL regrant: vld=%b idx=%0d cnt=%0d want 1/2/0", vld0, idx0, cnt0);
        end
        req = '0; valid = 1'b0;
    endtask

    task automatic test_idle_ignores_valid();
        do_reset();
        valid = 1'b1; tail = 1'b1;
        repeat (3) step();
        req = 5'b00001; valid = 1'b0; tail = 1'b0;
        step();
        vectors++;
        if (vld0 !== 1'b1 || idx0 !== 3'd0 || cnt0 !== 8'd0 || vld1 !== 1'b1 || cnt1 !== 8'd0) begin
            miscompares++;
            $display("FAIL idle_valid: vld=%b idx=%0d cnt=%0d tvld=%b tcnt=%0d want 1/0/0/1/0",
                     vld0, idx0, cnt0, vld1, cnt1);
        end
        req = '0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        req = 5'b00100;
        step();
        req = '0; valid = 1'b1;
        repeat (5) step();
        valid = 1'b0; req = 5'b01000;
        step();
        req = '0; valid = 1'b1;
        repeat (3) step();
        vectors++;
        if (vld0 !== 1'b1 || idx0 !== 3'd3 || cnt0 !== 8'd3) begin
            miscompares++;
            $display("FAIL midpkt_pre: vld=%b idx=%0d cnt=%0d want 1/3/3", vld0, idx0, cnt0);
        end
        rst = 1'b1;
        step();
        vectors++;
        if (vld0 !== 1'b0 || cnt0 !== 8'd0 || idx0 !== 3'd7 || oh0 !== 5'b0) begin
            miscompares++;
            $display("FAIL midpkt_reset: vld=%b cnt=%0d idx=%0d oh=%b want 0/0/7/00000", vld0, cnt0, idx0, oh0);
        end
        rst = 1'b0; valid = 1'b0; req = 5'b10001;
        step();
        vectors++;
        if (vld0 !== 1'b1 || idx0 !== 3'd0) begin
            miscompares++;
            $display("FAIL midpkt_after: vld=%b idx=%0d want 1/0", vld0, idx0);
        end
        req = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        req = 5'b10000;
        step();
        vectors++;
        if (vld0 !== 1'b1 || idx0 !== 3'd4 || oh0 !== 5'b10000) begin
            miscompares++;
            $display("FAIL wrap_grant: vld=%b idx=%0d oh=%b want 1/4/10000", vld0, idx0, oh0);
        end
        req = 5'b10001; valid = 1'b1;
        repeat (5) step();
        vectors++;
        if (vld0 !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_release: vld=%b want 0", vld0);
        end
        valid = 1'b0;
        step();
        vectors++;
        if (vld0 !== 1'b1 || idx0 !== 3'd0 || oh0 !== 5'b00001) begin
            miscompares++;
            $display("FAIL wrap_next: vld=%b idx=%0d oh=%b want 1/0/00001", vld0, idx0, oh0);
        end
        req = '0;
    endtask

    task automatic test_tail_mode();
        do_reset();
        req = 5'b00001;
        step();
        vectors++;
        if (vld1 !== 1'b1 || idx1 !== 3'd0) begin
            miscompares++;
            $display("FAIL tail_grant: vld=%b idx=%0d want 1/0", vld1, idx1);
        end
        req = '0;
        // Seven flits with gaps; tail is raised only during gaps, which must not release.
        for (int i = 0; i < 14; i++) begin
            valid = (i % 2 == 0);
            tail  = (i % 2 == 1);
            step();
        end
        vectors++;
        if (vld1 !== 1'b1 || cnt1 !== 8'd7 || idx1 !== 3'd0) begin
            miscompares++;
            $display("FAIL tail_pre: vld=%b cnt=%0d idx=%0d want 1/7/0", vld1, cnt1, idx1);
        end
        valid = 1'b1; tail = 1'b1;
        step();
        vectors++;
        if (vld1 !== 1'b0 || cnt1 !== 8'd0 || idx1 !== 3'd7) begin
            miscompares++;
            $display("FAIL tail_release: vld=%b cnt=%0d idx=%0d want 0/0/7", vld1, cnt1, idx1);
        end
        valid = 1'b0; tail = 1'b0;
    endtask

    task automatic test_single_flit();
        do_reset();
        req = 5'b00010;
        step();
        vectors++;
        if (vld2 !== 1'b1 || idx2 !== 3'd1) begin
            miscompares++;
            $display("FAIL pkt1_grant: vld=%b idx=%0d want 1/1", vld2, idx2);
        end
        req = '0; valid = 1'b1;
        step();
        vectors++;
        if (vld2 !== 1'b0 || cnt2 !== 8'd0 || vld0 !== 1'b1 || cnt0 !== 8'd1) begin
            miscompares++;
            $display("FAIL pkt1_release: vld=%b cnt=%0d (pkt5 vld=%b cnt=%0d) want 0/0 (1/1)", vld2, cnt2, vld0, cnt0);
        end
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_mask_hold();
        test_regrant();
        test_idle_ignores_valid();
        test_reset_mid_packet();
        test_wrap();
        test_tail_mode();
        test_single_flit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/noc_rr_port_arb.md
NOC_RR_PORT_ARB -- requirements
Module: noc_rr_port_arb

Interface
- REQ-001 Parameter NUM_PORTS, default 5: number of requesting input ports, legal range 2..16.
- REQ-002 Parameter PKT_FLITS, default 5: flits per packet in fixed-length mode, legal range 1..256.
- REQ-003 Parameter TAIL_MODE, default 0: 0 releases the grant by flit count; 1 releases it on a tail flag.
- REQ-004 Derived IDX_W = $clog2(NUM_PORTS+1); the all-ones IDX_W code is reserved as NONE.
- REQ-005 clk  input  1  clock; all state updates on the rising edge.
- REQ-006 rst  input  1  reset, synchronous, active-high.
- REQ-007 req_i  input  NUM_PORTS  per-port request; bit i = port i wants this output.
- REQ-008 mask_i  input  NUM_PORTS  per-port mask; 1 = port i is not eligible for a new grant.
- REQ-009 valid_i  input  1  a flit of the granted packet was transferred this cycle.
- REQ-010 tail_i  input  1  the transferred flit is the packet tail; used only when TAIL_MODE=1.
- REQ-011 grant_idx_o  output  IDX_W  granted port index, or NONE.
- REQ-012 grant_oh_o  output  NUM_PORTS  one-hot grant, all zeros when no grant.
- REQ-013 grant_vld_o  output  1  a grant is held.
- REQ-014 flit_cnt_o  output  8  flits transferred in the current packet.

Function
- REQ-015 The FSM SHALL have two states: IDLE and LOCKED. All outputs SHALL be registered.
- REQ-016 Eligibility: eligible = req_i & ~mask_i, evaluated only in IDLE.
- REQ-017 In IDLE with eligible != 0, the first eligible port searched cyclically from rr_ptr SHALL be granted at the next edge, and the FSM SHALL move to LOCKED; latency from request to grant is 1 cycle.
- REQ-018 In IDLE with eligible == 0, the block SHALL stay in IDLE with grant_vld_o=0, grant_oh_o=0, and grant_idx_o=NONE.
- REQ-019 In IDLE, valid_i and tail_i SHALL be ignored.
- REQ-020 In LOCKED, the grant SHALL be held regardless of req_i or mask_i changes, including withdrawal of the request by the granted port.
- REQ-021 In LOCKED, each cycle with valid_i=1 SHALL increment flit_cnt, saturating at 255.
- REQ-022 Release condition, TAIL_MODE=0: valid_i=1 while flit_cnt == PKT_FLITS-1.
- REQ-023 Release condition, TAIL_MODE=1: valid_i=1 and tail_i=1.
- REQ-024 On release, at the next edge:
  - the FSM SHALL go to IDLE;
  - grant outputs SHALL clear;
  - flit_cnt SHALL be set to 0;
  - rr_ptr SHALL be set to (granted index + 1) mod NUM_PORTS.
- REQ-025 After release there SHALL be exactly one IDLE bubble cycle before the next grant appears, so back-to-back packets are granted at best every PKT_FLITS+1 cycles.
- REQ-026 PKT_FLITS=1 in TAIL_MODE=0 SHALL release on the first valid_i.
- REQ-027 rr_ptr SHALL change only on release, never on a grant alone.
- REQ-028 If the granted port is the only eligible requester after release, it SHALL be regranted.
- REQ-029 Fairness: with all ports continuously eligible, each port SHALL be granted once per NUM_PORTS packets.
- REQ-030 Wrap-around: port NUM_PORTS-1 released SHALL set rr_ptr=0.

Reset
- REQ-031 On rst=1, at the next edge the state SHALL go to IDLE, with rr_ptr=0, flit_cnt=0, grant_vld_o=0, grant_oh_o=0, and grant_idx_o=NONE.
- REQ-032 rst SHALL override all other inputs, including mid-packet in LOCKED; the grant is dropped with no release side effects.
- REQ-033 The first grant after reset SHALL favour port 0.

Verification (NUM_PORTS=5, PKT_FLITS=5, TAIL_MODE=0 unless stated)
- REQ-034 Reset, then req_i=5'b00100 -> one cycle later grant_idx_o=2, grant_oh_o=5'b00100, grant_vld_o=1; after 5 valid_i pulses -> grant_idx_o=7 (NONE) for one cycle.
- REQ-035 req_i=5'b11111 held, valid_i=1 continuously -> grants in order 0,1,2,3,4,0 with 6-cycle spacing.
- REQ-036 req_i=5'b00011 and mask_i=5'b00001 -> grant to port 1; the granted port drops req_i mid-packet -> the grant is held until the 5th flit.
- REQ-037 Reset asserted after 3 of 5 flits -> grant_vld_o=0 and flit_cnt_o=0 next cycle; a following req_i=5'b10001 -> grant to port 0.
- REQ-038 TAIL_MODE=1: 8 flits with tail_i on the 8th -> release after the 8th, with flit_cnt_o=7 before release; valid_i gaps do not release.
- REQ-039 req_i=5'b10000 released -> rr_ptr=0; next req_i=5'b10001 -> port 0 granted (wrap-around).
